// File: rtl/syn_m_pkg.sv
// Shared sync-link definitions: transmit FSM state encoding, frame limits and frame payload.
package syn_m_pkg;

  localparam int unsigned MAX_FRAME_BYTES = 4;
  localparam int unsigned LEN_W           = 3;
  localparam int unsigned FRAME_W         = 32;
  localparam int unsigned ST_W            = 4;

  localparam logic [ST_W-1:0] S_IDLE = 4'd0;
  localparam logic [ST_W-1:0] S_LOAD = 4'd1;
  localparam logic [ST_W-1:0] S_FIRE = 4'd2;
  localparam logic [ST_W-1:0] S_WAIT = 4'd3;
  localparam logic [ST_W-1:0] S_NEXT = 4'd4;
  localparam logic [ST_W-1:0] S_DONE = 4'd5;

  typedef struct packed {
    logic [FRAME_W-1:0] data;
    logic [LEN_W-1:0]   len;
  } frame_t;

  // Byte counts above the frame capacity are treated as a full frame.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_FRAME_BYTES)) ? LEN_W'(MAX_FRAME_BYTES) : len;
  endfunction

endpackage

// File: rtl/syn_m_rr_arb.sv
// Combinational round-robin pick: first set request searching upward from ptr, wrapping.
module syn_m_rr_arb #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  localparam int unsigned PW = IDX_W + 1;

  logic [PW-1:0] pos;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(NREQ)) pos = pos - PW'(NREQ);
      if (!any_c && req[pos[IDX_W-1:0]]) begin
        any_c                 = 1'b1;
        idx_c                 = pos[IDX_W-1:0];
        gnt_c[pos[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syn_m_tx_arb.sv
// Round-robin arbiter sharing the byte-serial sync-link TX PHY between NREQ frame sources.
// Optional per-byte done_tx timeout enabled by SYN_M_TX_ARB_TIMEOUT_EN.
module syn_m_tx_arb
  import syn_m_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter logic [19:0] TIMEOUT = 20'd100000
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [FRAME_W*NREQ-1:0] req_data,
  input  logic [LEN_W*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    fire_tx,
  output logic [7:0]              data_tx,
  input  logic                    done_tx,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 2;

  logic [ST_W-1:0]    state, state_nx;
  logic [FRAME_W-1:0] shift, shift_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   win_len_c;
  logic [IDX_W-1:0]   win, rr;
  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               to_hit;
  frame_t             win_frame;

  syn_m_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arb (
    .req   (req),
    .ptr   (rr),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  // Frame of the registered winner; only consumed in LOAD.
  always_comb begin
    win_frame = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_frame.data = req_data[FRAME_W*i +: FRAME_W];
        win_frame.len  = req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  assign win_len_c = clamp_len(win_frame.len);

`ifdef SYN_M_TX_ARB_TIMEOUT_EN
  logic [19:0] tcnt;

  // Cycles spent in WAIT for the current byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == S_FIRE) begin
      tcnt <= '0;
    end else if (state == S_WAIT) begin
      tcnt <= tcnt + 20'd1;
    end
  end

  assign to_hit = (state == S_WAIT) && !done_tx && (tcnt == TIMEOUT - 20'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (arb_any) state_nx = S_LOAD;
      S_LOAD: begin
        shift_nx = win_frame.data;
        cnt_nx   = '0;
        state_nx = (win_len_c == '0) ? S_DONE : S_FIRE;
      end
      S_FIRE: state_nx = S_WAIT;
      S_WAIT: begin
        if (done_tx) begin
          state_nx = (cnt == CNT_W'(len - LEN_W'(1))) ? S_DONE : S_NEXT;
        end else if (to_hit) begin
          state_nx = S_DONE;
        end
      end
      S_NEXT: begin
        shift_nx = {shift[FRAME_W-9:0], 8'h00};
        cnt_nx   = cnt + CNT_W'(1);
        state_nx = S_FIRE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and outputs, registered against the next state so they line up with it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      cnt     <= '0;
      len     <= '0;
      win     <= '0;
      rr      <= '0;
      gnt     <= '0;
      ack     <= '0;
      fire_tx <= 1'b0;
      data_tx <= 8'h00;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      shift   <= shift_nx;
      cnt     <= cnt_nx;
      fire_tx <= (state_nx == S_FIRE);
      busy    <= (state_nx != S_IDLE);
      err     <= to_hit;
      ack     <= (state_nx == S_DONE) ? gnt : '0;
      if (state_nx == S_FIRE) data_tx <= shift_nx[FRAME_W-1 -: 8];
      if (state == S_LOAD) len <= win_len_c;
      if (state == S_IDLE && arb_any) begin
        win <= arb_idx;
        gnt <= arb_gnt;
      end else if (state_nx == S_IDLE) begin
        gnt <= '0;
      end
      if (state == S_DONE) begin
        rr <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_syn_m_tx_arb.sv
// Scoreboard bench for syn_m_tx_arb: queued frame model predicts PHY bytes, grants and acks.
module tb_syn_m_tx_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned MAXF = 4;
`ifdef SYN_M_TX_ARB_TIMEOUT_EN
  localparam logic [19:0] TB_TO = 20'd50;
`else
  localparam logic [19:0] TB_TO = 20'd100000;
`endif

  logic                 clk_sys = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [3*NREQ-1:0]    req_len;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 fire_tx;
  logic [7:0]           data_tx;
  logic                 done_tx;
  logic                 busy;
  logic                 err;

  syn_m_tx_arb #(.NREQ(NREQ), .TIMEOUT(TB_TO)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_len  (req_len),
    .gnt      (gnt),
    .ack      (ack),
    .fire_tx  (fire_tx),
    .data_tx  (data_tx),
    .done_tx  (done_tx),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic       is_ack;
    logic [2:0] src;
    logic [7:0] data;
    logic [2:0] nb;
    logic       err;
  } ev_t;

  ev_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int phy_pend = 0;
  int phy_fixed = 0;
  bit phy_hold = 1'b0;
  bit phy_spur = 1'b0;
  bit mon_en = 1'b1;
  int scr_mode = 0;
  int m_ptr = 0;

  logic [31:0] f_data [NREQ][MAXF];
  logic [2:0]  f_len  [NREQ][MAXF];
  int          f_cnt  [NREQ];
  int          f_head [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] s);
    logic [NREQ-1:0] r;
    r = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  always @(posedge clk_sys) cyc <= cyc + 1;

  // PHY model: done_tx a few cycles after each fire_tx.
  initial begin
    done_tx = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      done_tx = 1'b0;
      if (phy_spur) begin
        done_tx  = 1'b1;
        phy_spur = 1'b0;
      end
      if (phy_pend > 0) begin
        phy_pend--;
        if (phy_pend == 0) begin
          done_tx       = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (fire_tx && !phy_hold) phy_pend = (phy_fixed > 0) ? phy_fixed : int'($urandom_range(1, 6));
    end
  end

  task automatic present(input int i);
    req[i]            = 1'b1;
    req_data[32*i +: 32] = f_data[i][f_head[i]];
    req_len[3*i +: 3]    = f_len[i][f_head[i]];
  endtask

  // Sources: advance on ack, optionally disturb inputs while their frame is on the wire.
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          f_head[i]++;
          if (f_head[i] < f_cnt[i]) present(i);
          else req[i] = 1'b0;
        end else if (scr_mode != 0 && gnt[i] && fire_tx) begin
          if (scr_mode == 2 || $urandom_range(0, 1) == 1) begin
            req_data[32*i +: 32] = $urandom;
            req_len[3*i +: 3]    = 3'($urandom_range(0, 7));
            if (scr_mode == 2 || $urandom_range(0, 3) == 0) req[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every fire_tx or ack is matched against the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_sys);
      if (mon_en && rst_n && (fire_tx || ack != '0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected output", 32'({fire_tx, ack}), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("event kind", 32'(ack != '0), 32'(e.is_ack));
          if (fire_tx && !e.is_ack) begin
            check("data_tx", 32'(data_tx), 32'(e.data));
            check("gnt at fire", 32'(gnt), 32'(onehot(e.src)));
            check("busy at fire", 32'(busy), 32'(1));
          end
          if (ack != '0 && e.is_ack) begin
            check("ack src", 32'(ack), 32'(onehot(e.src)));
            check("err at ack", 32'(err), 32'(e.err));
            if (e.nb != 0 && !e.err) check("done to ack latency", 32'(cyc - last_done_cyc), 32'(1));
          end
        end
      end
    end
  end

  task automatic clear_frames();
    for (int i = 0; i < NREQ; i++) begin
      f_cnt[i]  = 0;
      f_head[i] = 0;
    end
  endtask

  task automatic add_frame(input int i, input logic [31:0] d, input logic [2:0] l);
    if (f_cnt[i] < MAXF) begin
      f_data[i][f_cnt[i]] = d;
      f_len[i][f_cnt[i]]  = l;
      f_cnt[i]++;
    end
  endtask

  // Reference: all queued frames requested at once; serve rr order, up to 4 bytes MSB first.
  task automatic build_model();
    int rem [NREQ];
    int hd  [NREQ];
    int total;
    int s;
    int n;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = f_cnt[i];
      hd[i]  = 0;
      total += f_cnt[i];
    end
    while (total > 0) begin
      s = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (s < 0 && rem[(m_ptr + k) % NREQ] > 0) s = (m_ptr + k) % NREQ;
      end
      n = (f_len[s][hd[s]] > 4) ? 4 : int'(f_len[s][hd[s]]);
      for (int b = 0; b < n; b++) begin
        exp_q.push_back('{is_ack: 1'b0, src: 3'(s), data: 8'(f_data[s][hd[s]] >> (24 - 8*b)),
                          nb: 3'(n), err: 1'b0});
      end
      exp_q.push_back('{is_ack: 1'b1, src: 3'(s), data: 8'h00, nb: 3'(n), err: 1'b0});
      m_ptr = (s + 1) % NREQ;
      rem[s]--;
      hd[s]++;
      total--;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 4000; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk_sys);
    end
    check(name, 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  // Raise every queued source in the same IDLE cycle, then wait for the model to drain.
  task automatic run_batch(input string name, input bit lat_chk);
    int n;
    build_model();
    for (int i = 0; i < NREQ; i++) begin
      f_head[i] = 0;
      if (f_cnt[i] > 0) present(i);
      else req[i] = 1'b0;
    end
    if (lat_chk) begin
      n = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk_sys); #1;
        n++;
        if (fire_tx || ack != '0) break;
      end
      check({name, " first response latency"}, 32'(n), 32'(2));
    end
    drain({name, " drain"});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " gnt"},     32'(gnt),     32'(0));
    check({tag, " ack"},     32'(ack),     32'(0));
    check({tag, " fire_tx"}, 32'(fire_tx), 32'(0));
    check({tag, " data_tx"}, 32'(data_tx), 32'(0));
    check({tag, " busy"},    32'(busy),    32'(0));
    check({tag, " err"},     32'(err),     32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    int fcyc;
    int ecyc;
    int tot;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    req_len  = '0;
    clear_frames();
    repeat (3) @(posedge clk_sys);
    #1;
    check_quiet("reset");
    @(negedge clk_sys) rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    clear_frames();
    phy_fixed = 10;
    add_frame(0, 32'hA1B2C3D4, 3'd4);
    run_batch("single frame", 1'b1);
    phy_fixed = 0;

    clear_frames();
    add_frame(0, 32'h5A5A5A5A, 3'd0);
    run_batch("zero length", 1'b1);

    clear_frames();
    add_frame(1, 32'hCAFEF00D, 3'd7);
    run_batch("oversize length", 1'b0);

    clear_frames();
    add_frame(0, 32'h11000001, 3'd1);
    add_frame(0, 32'h11000002, 3'd1);
    add_frame(1, 32'h22000001, 3'd1);
    add_frame(1, 32'h22000002, 3'd1);
    run_batch("round robin", 1'b0);

    clear_frames();
    scr_mode = 2;
    add_frame(0, 32'h0BADBEEF, 3'd4);
    run_batch("mid-frame change", 1'b0);
    scr_mode = 0;

    phy_spur = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("idle after stray done_tx", 32'(busy), 32'(0));

    scr_mode = 1;
    for (int b = 0; b < 10; b++) begin
      clear_frames();
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        nf = int'($urandom_range(0, 3));
        for (int k = 0; k < nf; k++) add_frame(i, $urandom, 3'($urandom_range(0, 7)));
        tot += nf;
      end
      if (tot == 0) add_frame(int'($urandom_range(0, NREQ - 1)), $urandom, 3'd2);
      run_batch("random batch", 1'b0);
    end
    scr_mode = 0;

    // Leave the rr pointer at source 1, then reset in the middle of a source 1 frame.
    clear_frames();
    add_frame(0, 32'h01020304, 3'd1);
    run_batch("pre-reset", 1'b0);
    mon_en    = 1'b0;
    phy_fixed = 4;
    req[1]         = 1'b1;
    req_data[63:32] = 32'hDEADBEEF;
    req_len[5:3]    = 3'd4;
    nf = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_sys); #1;
      if (fire_tx) nf++;
      if (nf == 2) break;
    end
    check("fires before reset", 32'(nf), 32'(2));
    @(posedge clk_sys); #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async reset");
    req      = '0;
    phy_pend = 0;
    nf = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_sys); #1;
      if (ack != '0) nf++;
    end
    check("ack during reset", 32'(nf), 32'(0));
    @(negedge clk_sys) rst_n = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    phy_fixed = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    mon_en = 1'b1;
    clear_frames();
    add_frame(0, 32'h0A0B0C0D, 3'd2);
    add_frame(1, 32'h1A1B1C1D, 3'd1);
    run_batch("after reset", 1'b1);

`ifdef SYN_M_TX_ARB_TIMEOUT_EN
    clear_frames();
    add_frame(0, 32'hF1F2F3F4, 3'd3);
    exp_q.push_back('{is_ack: 1'b0, src: 3'd0, data: 8'hF1, nb: 3'd3, err: 1'b0});
    exp_q.push_back('{is_ack: 1'b1, src: 3'd0, data: 8'h00, nb: 3'd3, err: 1'b1});
    m_ptr    = 1;
    phy_hold = 1'b1;
    f_head[0] = 0;
    present(0);
    fcyc = -1;
    ecyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_sys); #1;
      if (fire_tx && fcyc < 0) fcyc = cyc;
      if (err) begin
        ecyc = cyc;
        break;
      end
    end
    // TIMEOUT WAIT cycles after the FIRE cycle, then DONE carries err with ack.
    check("timeout err delay", 32'(ecyc - fcyc), 32'(int'(TB_TO) + 1));
    drain("timeout drain");
    check("busy after timeout", 32'(busy), 32'(0));
    phy_hold = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
